// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: clears registers 1..63 after reset, then arbitrates buffered writebacks
// round-robin onto the single register-file write port.
module regfile_write_scheduler #(
    parameter int NUM_WB_PORTS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WB_PORTS-1:0] wb_valid_i,
    input  logic [5:0]              wb_addr_i [NUM_WB_PORTS],
    input  logic [31:0]             wb_data_i [NUM_WB_PORTS],
    output logic [NUM_WB_PORTS-1:0] wb_ready_o,
    output logic [5:0]              rf_write_addr_o,
    output logic [31:0]             rf_new_data_o,
    output logic                    rf_commit_o,
    output logic                    init_done_o,
    output logic                    zero_drop_o
);
    localparam int PW = $clog2(NUM_WB_PORTS);
    typedef enum logic {INIT, RUN} state_t;
    state_t state_q, state_d;
    logic [5:0] init_ptr_q, init_ptr_d;
    logic [NUM_WB_PORTS-1:0] buf_valid_q, buf_valid_d, grant, accept, load, zero_hit;
    logic [5:0] buf_addr_q [NUM_WB_PORTS];
    logic [31:0] buf_data_q [NUM_WB_PORTS];
    logic [PW-1:0] rr_ptr_q, rr_ptr_d, gidx;
    logic [PW:0] scan;
    logic zero_drop_q, zero_drop_d;
    // First valid buffer at or after rr_ptr wins; only in RUN.
    always_comb begin
        grant = '0;
        gidx = '0;
        scan = '0;
        if (state_q == RUN) begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
                scan = (scan >= (PW+1)'(NUM_WB_PORTS)) ? scan - (PW+1)'(NUM_WB_PORTS) : scan;
                if (grant == '0 && buf_valid_q[scan[PW-1:0]]) begin
                    grant[scan[PW-1:0]] = 1'b1;
                    gidx = scan[PW-1:0];
                end
            end
        end
    end
    assign init_done_o = state_q == RUN;
    assign zero_drop_o = zero_drop_q;
    assign wb_ready_o = {NUM_WB_PORTS{init_done_o}} & (~buf_valid_q | grant);
    assign accept = wb_valid_i & wb_ready_o;
    // rf_commit follows rst_n in INIT so it reads 0 while reset is held.
    assign rf_commit_o = (state_q == INIT) ? rst_n : |grant;
    assign rf_write_addr_o = (state_q == INIT) ? init_ptr_q : (|grant ? buf_addr_q[gidx] : 6'd0);
    assign rf_new_data_o = (state_q == RUN && |grant) ? buf_data_q[gidx] : 32'd0;
    always_comb begin
        state_d = (state_q == INIT && init_ptr_q == 6'd63) ? RUN : state_q;
        init_ptr_d = (state_q == INIT) ? init_ptr_q + 6'd1 : init_ptr_q;
        rr_ptr_d = !(|grant) ? rr_ptr_q : (gidx == PW'(NUM_WB_PORTS-1)) ? '0 : gidx + PW'(1);
        for (int i = 0; i < NUM_WB_PORTS; i++) begin
            zero_hit[i] = accept[i] & (wb_addr_i[i] == 6'd0);
            load[i] = accept[i] & (wb_addr_i[i] != 6'd0);
        end
        buf_valid_d = load | (buf_valid_q & ~grant);
        zero_drop_d = |zero_hit;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            init_ptr_q <= 6'd1;
            buf_valid_q <= '0;
            rr_ptr_q <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            init_ptr_q <= init_ptr_d;
            buf_valid_q <= buf_valid_d;
            rr_ptr_q <= rr_ptr_d;
            zero_drop_q <= zero_drop_d;
        end
    end
    // Payload is qualified by buf_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WB_PORTS; i++) begin
            if (load[i]) begin
                buf_addr_q[i] <= wb_addr_i[i];
                buf_data_q[i] <= wb_data_i[i];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: random and directed writebacks checked by a scoreboard
// that predicts commits from per-port pending queues and a round-robin pointer.
module tb_regfile_write_scheduler;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] wb_valid = '0;
    logic [5:0] wb_addr [N];
    logic [31:0] wb_data [N];
    logic [N-1:0] wb_ready;
    logic [5:0] rf_write_addr;
    logic [31:0] rf_new_data;
    logic rf_commit, init_done, zero_drop;

    int n_cmp = 0;
    int n_fail = 0;
    logic [37:0] q [N][$];
    int rr = 0;
    int init_exp = 1;
    bit seen_run = 0;
    bit zd_exp = 0;

    regfile_write_scheduler #(.NUM_WB_PORTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .wb_ready_o(wb_ready), .rf_write_addr_o(rf_write_addr), .rf_new_data_o(rf_new_data),
        .rf_commit_o(rf_commit), .init_done_o(init_done), .zero_drop_o(zero_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every cycle's write-port activity against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!init_done) begin
                chk(wb_ready == '0, "init_ready", 64'(wb_ready), 0);
                chk(rf_commit && rf_write_addr == 6'(init_exp) && rf_new_data == 0, "init_sweep",
                    {25'd0, rf_commit, rf_write_addr, rf_new_data}, {25'd0, 1'b1, 6'(init_exp), 32'd0});
                init_exp++;
            end else begin
                int exp_p;
                logic [37:0] e;
                if (!seen_run) begin
                    chk(init_exp == 64, "init_len", 64'(init_exp), 64);
                    seen_run = 1;
                end
                chk(zero_drop == zd_exp, "zero_drop", 64'(zero_drop), 64'(zd_exp));
                chk(!(rf_commit && rf_write_addr == 0), "commit_addr0", 64'(rf_write_addr), 1);
                exp_p = -1;
                for (int k = 0; k < N; k++)
                    if (exp_p < 0 && q[(rr + k) % N].size() > 0) exp_p = (rr + k) % N;
                chk(rf_commit == (exp_p >= 0), "commit_valid", 64'(rf_commit), 64'(exp_p >= 0));
                if (rf_commit && exp_p >= 0) begin
                    e = q[exp_p].pop_front();
                    chk({rf_write_addr, rf_new_data} == e, "commit_write",
                        64'({rf_write_addr, rf_new_data}), 64'(e));
                    rr = (exp_p + 1) % N;
                end
            end
        end
    end

    // One cycle of stimulus: inputs already driven, returns which ports were accepted.
    task automatic tick(output logic [N-1:0] acc);
        logic [N-1:0] a;
        bit z;
        @(negedge clk);
        a = wb_valid & wb_ready;
        @(posedge clk);
        z = 0;
        for (int p = 0; p < N; p++)
            if (a[p]) begin
                if (wb_addr[p] == 0) z = 1;
                else q[p].push_back({wb_addr[p], wb_data[p]});
            end
        zd_exp = z;
        #1;
        acc = a;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 80 && !init_done; i++) @(negedge clk);
        chk(init_done, "init_done_timeout", 64'(init_done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check();
        logic [N-1:0] acc;
        wb_valid = '0;
        repeat (6) tick(acc);
        for (int p = 0; p < N; p++) chk(q[p].size() == 0, "drained", 64'(q[p].size()), 0);
    endtask

    initial begin
        logic [N-1:0] acc;
        int rc [N];
        for (int p = 0; p < N; p++) begin
            wb_addr[p] = '0;
            wb_data[p] = '0;
        end
        #3;
        chk({rf_commit, init_done, zero_drop, wb_ready} == '0, "reset_outputs",
            64'({rf_commit, init_done, zero_drop, wb_ready}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();

        // Single write then a stream to 5,6,7 on port 0.
        wb_valid = 3'b001; wb_addr[0] = 6'd5; wb_data[0] = 32'hDEADBEEF;
        tick(acc);
        chk(acc[0], "single_accept", 64'(acc), 1);
        wb_valid = '0;
        tick(acc);
        wb_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            wb_addr[0] = 6'(5 + i); wb_data[0] = 32'h1000 + i;
            tick(acc);
            chk(acc[0], "stream_ready", 64'(acc), 1);
        end
        drain_check();

        // All ports contend every cycle: each port accepted 1 cycle in 3 at steady state.
        for (int p = 0; p < N; p++) rc[p] = 0;
        wb_valid = '1;
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < N; p++) begin
                wb_addr[p] = 6'(1 + p * 20 + i);
                wb_data[p] = {8'(p), 24'(i)};
            end
            tick(acc);
            if (i >= 3) for (int p = 0; p < N; p++) rc[p] += int'(acc[p]);
        end
        for (int p = 0; p < N; p++) chk(rc[p] == 3, "rr_share", 64'(rc[p]), 3);
        drain_check();

        // Write to register 0 on port 1 is accepted and discarded.
        wb_valid = 3'b010; wb_addr[1] = 6'd0; wb_data[1] = 32'h55;
        tick(acc);
        chk(acc[1], "zero_accept", 64'(acc), 2);
        drain_check();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < N; p++) begin
                wb_valid[p] = 1'($urandom % 2);
                wb_addr[p] = ($urandom % 16 == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                wb_data[p] = $urandom;
            end
            tick(acc);
        end
        drain_check();

        // Reset mid-RUN with all buffers full: nothing buffered may commit afterwards.
        wb_valid = '1;
        for (int p = 0; p < N; p++) begin
            wb_addr[p] = 6'(10 + p); wb_data[p] = 32'hBAD0 + p;
        end
        tick(acc);
        tick(acc);
        #2 rst_n = 1'b0;
        #1;
        chk({rf_commit, init_done, zero_drop, wb_ready} == '0, "midrun_reset",
            64'({rf_commit, init_done, zero_drop, wb_ready}), 0);
        wb_valid = '0;
        for (int p = 0; p < N; p++) q[p].delete();
        rr = 0; init_exp = 1; seen_run = 0; zd_exp = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();
        for (int i = 0; i < 100; i++) begin
            for (int p = 0; p < N; p++) begin
                wb_valid[p] = 1'($urandom % 2);
                wb_addr[p] = 6'($urandom_range(63, 0));
                wb_data[p] = $urandom;
            end
            tick(acc);
        end
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
